dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the pipelined RISC-V core, sitting on the far side of the memory-stage interface. It accepts one load or store per request from the M stage: the address is the M-stage ALU result and the write data is the M-stage store data. It holds the pipeline with a stall for a fixed access latency, then returns sign- or zero-extended load data on `RD` for capture by the M→W pipeline register. The array is an internal word-organised SRAM model with byte/halfword/word access and misalignment detection.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, default 2: stall cycles per access; ≥ 1.

- `CLK`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ReqM`  in  1  access request; held high by the pipeline while `StallM` = 1.
- `WeM`  in  1  1 = store, 0 = load; sampled with `ReqM`.
- `AddrM`  in  32  byte address.
- `WDataM`  in  32  store data; bytes taken from the low end.
- `Funct3M`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `RD`  out  32  load data, extended to 32 bits.
- `StallM`  out  1  freeze F/D/E/M stages.
- `RdValid`  out  1  one-cycle pulse: `RD` holds a fresh load result.
- `MisalignErr`  out  1  one-cycle pulse: access rejected.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUSY: latency countdown.
  - DONE: completion cycle.
- IDLE, `ReqM` = 1:
  - Capture `WeM`/`AddrM`/`WDataM`/`Funct3M` into hold registers.
  - Load the counter with `LATENCY`-1.
  - Go to BUSY, or directly to DONE when `LATENCY` = 1.
- BUSY: decrement the counter each cycle; leave for DONE on the edge where the counter is 1 (or 0 on entry).
- Array update on the edge entering DONE, using only the hold registers (inputs ignored after capture):
  - Store: write the enabled bytes. sb writes byte lane `AddrM[1:0]`; sh writes lanes {1,0} or {3,2} per `AddrM[1]`; sw writes all 4 lanes.
  - Load: read the word, select the lane(s), sign-extend for b/h, zero-extend for bu/hu, and register the result into `RD`.
- DONE:
  - `StallM` = 0 so the pipeline advances.
  - `RdValid` = 1 for a good load.
  - Return to IDLE unconditionally. `ReqM` seen in DONE belongs to the completing access and is not re-accepted.
- Word index = `AddrM[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored (aliasing wrap).
- Errors: halfword with `AddrM[0]` = 1, word with `AddrM[1:0]` ≠ 0, or `Funct3M` ∈ {011, 110, 111}.
  - No array write.
  - `RD` loaded with 0.
  - `MisalignErr` = 1 in DONE; `RdValid` = 0.
  - Latency is unchanged.
- Stores leave `RD` unchanged; `RD` holds its last load value until the next load completes.
- Read-after-write: a load issued after a store completes returns the stored data; there is no bypass requirement inside one access.

## Timing
- `StallM` = (state == IDLE & `ReqM`) | (state == BUSY). This is combinational, so the request cycle itself stalls.
- For a request first seen in cycle t:
  - `StallM` is high in cycles t … t+`LATENCY`-1.
  - DONE occurs in cycle t+`LATENCY`.
  - `RD` is valid from cycle t+`LATENCY` onward.
  - The next request can be accepted in cycle t+`LATENCY`+1.
- Back-to-back accesses: throughput is one access per `LATENCY`+1 cycles.
- `RdValid` and `MisalignErr` are registered pulses and are never both 1.
- Reset (async, any state, including mid-access):
  - State → IDLE; counter → 0; `RD` = 0; `RdValid` = 0; `MisalignErr` = 0.
  - `StallM` then follows `ReqM` combinationally.
  - An in-flight store is dropped, not written.
  - Array contents are not cleared.
- `ReqM` deasserted while BUSY: the access still completes; the FSM does not abort.

## Test plan
- `LATENCY` = 2, sw 0xDEADBEEF @0x10, then lw @0x10:
  - `StallM` is 1,1,0 for each access.
  - `RD` = 0xDEADBEEF with `RdValid` pulse in the load's DONE cycle.
- sb 0x80 @0x21, then lb @0x21 and lbu @0x21:
  - `RD` = 0xFFFFFF80, then 0x00000080.
  - Other bytes of word 8 unchanged.
- sh 0x1234 @0x42, lh @0x42:
  - `RD` = 0x00001234; word 16 lanes 0,1 untouched.
- lw @0x13 and sh @0x05:
  - `MisalignErr` pulse, `RD` = 0, no array change.
  - Stall length still `LATENCY`.
- Wrap: with `DEPTH_WORDS` = 1024, sw 0xA5A5A5A5 @0x1000, then lw @0x0 → 0xA5A5A5A5.
- Assert `rst` during BUSY of sw 0x11111111 @0x30:
  - Immediately: `StallM` = 0 with `ReqM` low, `RD` = 0.
  - A subsequent lw @0x30 returns the prior contents.
- `LATENCY` = 1 run: every access stalls exactly 1 cycle, then has one DONE cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage of the pipelined core.
// Accepts one load/store per request, stalls the pipeline for LATENCY
// cycles, then completes in a single DONE cycle. Loads return sign- or
// zero-extended data on RD. Misaligned or illegal accesses are rejected
// with a MisalignErr pulse and leave the array untouched.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        ReqM,
    input  logic        WeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WDataM,
    input  logic [2:0]  Funct3M,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        RdValid,
    output logic        MisalignErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            finish;          // this edge enters DONE
    logic            accept;          // request captured this edge

    // Hold registers for the access in flight (only the used address bits).
    logic            we_reg;
    logic [AW+1:0]   addr_reg;
    logic [31:0]     wdata_reg;
    logic [2:0]      funct3_reg;

    // Operands of the access: when LATENCY = 1 the completing edge is also
    // the capture edge, so the values being captured are used directly.
    logic            acc_we;
    logic [AW+1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic [2:0]      acc_funct3;

    logic            acc_err;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_lanes;
    logic [AW-1:0]   word_idx;
    logic            wr_en;
    logic            rd_en;
    logic [7:0]      rd_byte [4];
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     load_ext;

    logic [31:0]     rd_reg;
    logic            rdvalid_reg;
    logic            misalign_reg;

    // Upper address bits alias onto the array and are deliberately ignored.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^AddrM[31:AW+2];

    assign accept = (state_reg == IDLE) && ReqM;

    // State and latency counter registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, countdown and the combinational stall.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        StallM     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ReqM) begin
                    StallM   = 1'b1;
                    cnt_next = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (cnt_reg <= CW'(1)) begin
                    state_next = DONE;
                    finish     = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                // A request still high here belongs to the completing access.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request so later input changes cannot affect the access.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            funct3_reg <= '0;
        end else if (accept) begin
            we_reg     <= WeM;
            addr_reg   <= AddrM[AW+1:0];
            wdata_reg  <= WDataM;
            funct3_reg <= Funct3M;
        end
    end

    assign acc_we     = accept ? WeM           : we_reg;
    assign acc_addr   = accept ? AddrM[AW+1:0] : addr_reg;
    assign acc_wdata  = accept ? WDataM        : wdata_reg;
    assign acc_funct3 = accept ? Funct3M       : funct3_reg;
    assign word_idx   = acc_addr[AW+1:2];

    // Decode size/alignment into an error flag, byte enables and lane data.
    always_comb begin
        acc_err     = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = acc_wdata;
        case (acc_funct3)
            3'b000, 3'b100: begin
                byte_en     = 4'b0001 << acc_addr[1:0];
                wdata_lanes = {4{acc_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                acc_err     = acc_addr[0];
                byte_en     = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{acc_wdata[15:0]}};
            end
            3'b010: begin
                acc_err = (acc_addr[1:0] != 2'b00);
                byte_en = 4'b1111;
            end
            default: begin
                acc_err = 1'b1;
            end
        endcase
    end

    assign wr_en = finish && acc_we && !acc_err;
    assign rd_en = finish && !acc_we && !acc_err;

    // One byte-wide RAM per lane so each lane has its own write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            // Lane write on the edge entering DONE.
            always_ff @(posedge CLK) begin
                if (wr_en && byte_en[gi]) begin
                    lane_mem[word_idx] <= wdata_lanes[gi*8 +: 8];
                end
            end

            assign rd_byte[gi] = lane_mem[word_idx];
        end
    endgenerate

    // Lane selection and sign/zero extension of the raw word.
    always_comb begin
        sel_byte = rd_byte[acc_addr[1:0]];
        sel_half = acc_addr[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
        case (acc_funct3)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        endcase
    end

    // Registered load result and completion pulses; stores leave RD alone.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_reg       <= '0;
            rdvalid_reg  <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            rdvalid_reg  <= rd_en;
            misalign_reg <= finish && acc_err;
            if (finish && acc_err) begin
                rd_reg <= '0;
            end else if (rd_en) begin
                rd_reg <= load_ext;
            end
        end
    end

    assign RD          = rd_reg;
    assign RdValid     = rdvalid_reg;
    assign MisalignErr = misalign_reg;

endmodule
